// File: rtl/scoreboard_ring.sv
// In-order scoreboard ring between issue and commit, with multi-port writeback and flush.
// Optional operand forwarding lookup is enabled by defining SB_FORWARD_EN.
package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 8;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    ALU       = 3'd3,
    CTRL_FLOW = 3'd4,
    MULT      = 3'd5,
    CSR       = 3'd6
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception_t               ex;
  } scoreboard_entry;
endpackage

module scoreboard_ring
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = 8,
  parameter int unsigned NR_WB_PORTS = 3,
  parameter int unsigned TRANS_ID_W  = $clog2(NR_ENTRIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   issue_valid_i,
  input  scoreboard_entry                        issue_entry_i,
  output logic                                   issue_ready_o,
  output logic [TRANS_ID_W-1:0]                  issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_W-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]           wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]           wb_ex_i,
  output logic                                   commit_valid_o,
  output scoreboard_entry                        commit_entry_o,
  input  logic                                   commit_ack_i,
  output logic [TRANS_ID_W:0]                    count_o,
  input  logic [4:0]                             rs1_i,
  input  logic [4:0]                             rs2_i,
  output logic                                   rs1_busy_o,
  output logic                                   rs2_busy_o,
  output logic                                   rs1_fwd_o,
  output logic                                   rs2_fwd_o,
  output logic [63:0]                            rs1_data_o,
  output logic [63:0]                            rs2_data_o
);

  localparam logic [TRANS_ID_W:0] FULL_CNT = (TRANS_ID_W+1)'(NR_ENTRIES);

  scoreboard_entry             mem_q [NR_ENTRIES];
  scoreboard_entry             mem_d [NR_ENTRIES];
  logic [TRANS_ID_W-1:0]       head_q, head_d;
  logic [TRANS_ID_W-1:0]       tail_q, tail_d;
  logic [TRANS_ID_W:0]         count_q, count_d;
  logic                        issue_fire_s;
  logic                        commit_fire_s;

  // Distance from head decides occupancy, so full and empty never alias.
  function automatic logic in_flight(input logic [TRANS_ID_W-1:0] id,
                                     input logic [TRANS_ID_W-1:0] hd,
                                     input logic [TRANS_ID_W:0]   cnt);
    logic [TRANS_ID_W-1:0] off;
    off = id - hd;
    return ({1'b0, off} < cnt);
  endfunction

  assign issue_ready_o    = (count_q < FULL_CNT);
  assign issue_trans_id_o = tail_q;
  assign count_o          = count_q;
  assign commit_valid_o   = (count_q != {(TRANS_ID_W+1){1'b0}}) && mem_q[head_q].valid;
  assign commit_entry_o   = mem_q[head_q];
  assign issue_fire_s     = issue_valid_i & issue_ready_o;
  assign commit_fire_s    = commit_valid_o & commit_ack_i;

  // Next-state: flush, then writeback (lowest port first), commit, issue.
  always_comb begin
    logic [NR_ENTRIES-1:0] taken;
    logic [TRANS_ID_W-1:0] wid;
    logic                  wr;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    taken   = {NR_ENTRIES{1'b0}};
    wid     = {TRANS_ID_W{1'b0}};
    wr      = 1'b0;
    if (flush_i) begin
      for (int s = 0; s < NR_ENTRIES; s++) begin
        mem_d[s].valid = 1'b0;
      end
      head_d  = {TRANS_ID_W{1'b0}};
      tail_d  = {TRANS_ID_W{1'b0}};
      count_d = {(TRANS_ID_W+1){1'b0}};
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        wid = wb_trans_id_i[p];
        wr  = wb_valid_i[p] & in_flight(wid, head_q, count_q) & ~taken[wid];
        taken[wid]        = taken[wid] | wr;
        mem_d[wid].result = wr ? wb_data_i[p] : mem_d[wid].result;
        mem_d[wid].valid  = wr | mem_d[wid].valid;
        mem_d[wid].ex     = (wr & wb_ex_i[p].valid) ? wb_ex_i[p] : mem_d[wid].ex;
      end
      if (commit_fire_s) begin
        mem_d[head_q].valid = 1'b0;
        head_d = head_q + TRANS_ID_W'(1);
      end else begin
        head_d = head_q;
      end
      if (issue_fire_s) begin
        mem_d[tail_q]          = issue_entry_i;
        mem_d[tail_q].trans_id = TRANS_ID_BITS'(tail_q);
        mem_d[tail_q].valid    = issue_entry_i.valid | issue_entry_i.ex.valid;
        tail_d = tail_q + TRANS_ID_W'(1);
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + {{TRANS_ID_W{1'b0}}, issue_fire_s}
                        - {{TRANS_ID_W{1'b0}}, commit_fire_s};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= {TRANS_ID_W{1'b0}};
      tail_q  <= {TRANS_ID_W{1'b0}};
      count_q <= {(TRANS_ID_W+1){1'b0}};
      for (int s = 0; s < NR_ENTRIES; s++) begin
        mem_q[s] <= scoreboard_entry'({$bits(scoreboard_entry){1'b0}});
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int s = 0; s < NR_ENTRIES; s++) begin
        mem_q[s] <= mem_d[s];
      end
    end
  end

`ifdef SB_FORWARD_EN
  // Oldest-to-youngest scan; a later hit overrides, leaving the youngest writer.
  always_comb begin
    logic [TRANS_ID_W-1:0] idx;
    logic                  live, hit1, hit2;
    rs1_busy_o = 1'b0;
    rs2_busy_o = 1'b0;
    rs1_fwd_o  = 1'b0;
    rs2_fwd_o  = 1'b0;
    rs1_data_o = 64'd0;
    rs2_data_o = 64'd0;
    idx  = {TRANS_ID_W{1'b0}};
    live = 1'b0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      idx  = head_q + TRANS_ID_W'(i);
      live = ((TRANS_ID_W+1)'(i) < count_q) && (mem_q[idx].fu != NONE);
      hit1 = live && (mem_q[idx].rd == rs1_i) && (rs1_i != 5'd0);
      hit2 = live && (mem_q[idx].rd == rs2_i) && (rs2_i != 5'd0);
      rs1_busy_o = hit1 ? ~mem_q[idx].valid : rs1_busy_o;
      rs1_fwd_o  = hit1 ?  mem_q[idx].valid : rs1_fwd_o;
      rs1_data_o = hit1 ? (mem_q[idx].valid ? mem_q[idx].result : 64'd0) : rs1_data_o;
      rs2_busy_o = hit2 ? ~mem_q[idx].valid : rs2_busy_o;
      rs2_fwd_o  = hit2 ?  mem_q[idx].valid : rs2_fwd_o;
      rs2_data_o = hit2 ? (mem_q[idx].valid ? mem_q[idx].result : 64'd0) : rs2_data_o;
    end
  end
`else
  logic unused_rs_s;
  assign unused_rs_s = ^{rs1_i, rs2_i};
  assign rs1_busy_o  = 1'b0;
  assign rs2_busy_o  = 1'b0;
  assign rs1_fwd_o   = 1'b0;
  assign rs2_fwd_o   = 1'b0;
  assign rs1_data_o  = 64'd0;
  assign rs2_data_o  = 64'd0;
`endif

endmodule
